tlc_chain_shifter: RTL and testbench

- Parametrised serializer that drives NUM_CHAINS daisy-chained LED-driver shift chains in parallel. All chains share SCLK and LAT; each chain has its own SDO lane.
- After reset it writes a control latch, then streams grayscale latches fetched bit-by-bit from an upstream frame source.
- It rewrites the control latch periodically, or on demand.
- Sits between the frame buffer/HDMI capture path and the driver board connectors.

---
 rtl/tlc_chain_shifter.sv | 201 ++++++++++++++++++++
 tb/tb_tlc_chain_shifter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_chain_shifter.sv
// tlc_chain_shifter
// Serializer that drives NUM_CHAINS daisy-chained LED-driver shift chains in
// parallel. After reset it shifts the control latch, then streams grayscale
// latches fetched one bit index at a time from the upstream frame source.
// The control latch is rewritten every CTRL_REFRESH grayscale latches, or on
// a CTRL_FORCE request, at the next decision point.
//
// Ports
//   CLK_10M      system clock
//   RESET        synchronous active-high reset
//   ENABLE       permits starting new grayscale frames
//   FRAME_VALID  upstream has a frame ready
//   FRAME_ACK    one-cycle pulse on the first LAT cycle of a grayscale latch
//   CTRL_FORCE   pulse: request a control rewrite (sticky until serviced)
//   RD_EN        grayscale bit read strobe
//   RD_ADDR      bit index requested
//   RD_DATA      one bit per chain, valid the cycle after RD_EN
//   SCLK, LAT    shared shift clock and latch strobe
//   SDO          per-chain serial data
//   BUSY         low only while idle in GS_WAIT
//   CTRL_PHASE   high while a control latch is shifting or latching
//
// state   | meaning
// C_SETUP | control bit, SCLK low, SDO = CTRL_WORD[idx]
// C_HIGH  | control bit, SCLK high
// G_FETCH | grayscale bit read request (RD_EN)
// G_SETUP | grayscale bit, SCLK low, RD_DATA captured into SDO
// G_HIGH  | grayscale bit, SCLK high
// LATCH   | LAT high for LAT_WIDTH cycles
// GAP     | one cycle with LAT low, then decision
// GS_WAIT | idle, decision evaluated every cycle
module tlc_chain_shifter #(
    parameter int                    LATCH_SIZE   = 769,
    parameter int                    NUM_CHAINS   = 48,
    parameter int                    SCLK_DIV     = 1,
    parameter int                    LAT_WIDTH    = 1,
    parameter int                    CTRL_REFRESH = 10,
    parameter logic [LATCH_SIZE-1:0] CTRL_WORD    = '0
) (
    input  logic                          CLK_10M,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic                          FRAME_VALID,
    output logic                          FRAME_ACK,
    input  logic                          CTRL_FORCE,
    output logic                          RD_EN,
    output logic [$clog2(LATCH_SIZE)-1:0] RD_ADDR,
    input  logic [NUM_CHAINS-1:0]         RD_DATA,
    output logic                          SCLK,
    output logic                          LAT,
    output logic [NUM_CHAINS-1:0]         SDO,
    output logic                          BUSY,
    output logic                          CTRL_PHASE
);

    localparam int AW   = $clog2(LATCH_SIZE);
    localparam int IW   = $clog2(LATCH_SIZE + 1);
    localparam int TMAX = (SCLK_DIV > LAT_WIDTH) ? SCLK_DIV : LAT_WIDTH;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (CTRL_REFRESH > 0) ? $clog2(CTRL_REFRESH + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(LATCH_SIZE - 1);
    localparam logic [TW-1:0] SDIV_M1  = TW'(SCLK_DIV - 1);
    localparam logic [TW-1:0] LAT_M1   = TW'(LAT_WIDTH - 1);
    localparam logic [RW-1:0] REF_MAX  = RW'(CTRL_REFRESH);

    typedef enum logic [2:0] {
        C_SETUP, C_HIGH, G_FETCH, G_SETUP, G_HIGH, LATCH, GAP, GS_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic            force_q, force_nxt;
    logic [RW-1:0]   ref_cnt, ref_nxt;
    logic            mode_ctrl, mode_nxt;

    logic                  sclk_nxt, lat_nxt, rd_en_nxt, ack_nxt, busy_nxt, cph_nxt;
    logic [AW-1:0]         rd_addr_nxt;
    logic [NUM_CHAINS-1:0] sdo_nxt;
    logic                  decide, do_ctrl, lat_rise;

    // Outputs are registered from the next-state values so they line up with
    // the state they describe and all come out of reset clean.
    always_ff @(posedge CLK_10M) begin
        if (RESET) begin
            state      <= C_SETUP;
            idx        <= LAST_IDX;
            tmr        <= SDIV_M1;
            force_q    <= 1'b0;
            ref_cnt    <= '0;
            mode_ctrl  <= 1'b1;
            SCLK       <= 1'b0;
            LAT        <= 1'b0;
            SDO        <= '0;
            RD_EN      <= 1'b0;
            RD_ADDR    <= '0;
            FRAME_ACK  <= 1'b0;
            BUSY       <= 1'b1;
            CTRL_PHASE <= 1'b1;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tmr        <= tmr_nxt;
            force_q    <= force_nxt;
            ref_cnt    <= ref_nxt;
            mode_ctrl  <= mode_nxt;
            SCLK       <= sclk_nxt;
            LAT        <= lat_nxt;
            SDO        <= sdo_nxt;
            RD_EN      <= rd_en_nxt;
            RD_ADDR    <= rd_addr_nxt;
            FRAME_ACK  <= ack_nxt;
            BUSY       <= busy_nxt;
            CTRL_PHASE <= cph_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_nxt   = tmr;
        force_nxt = force_q | CTRL_FORCE;
        ref_nxt   = ref_cnt;
        mode_nxt  = mode_ctrl;
        decide    = 1'b0;
        do_ctrl   = force_q || ((CTRL_REFRESH != 0) && (ref_cnt == REF_MAX));

        case (state)
            C_SETUP, G_SETUP: begin
                if (tmr == '0) begin
                    state_nxt = (state == C_SETUP) ? C_HIGH : G_HIGH;
                    tmr_nxt   = SDIV_M1;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            C_HIGH, G_HIGH: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - TW'(1);
                end else if (idx == '0) begin
                    state_nxt = LATCH;
                    tmr_nxt   = LAT_M1;
                end else begin
                    idx_nxt   = idx - IW'(1);
                    state_nxt = (state == C_HIGH) ? C_SETUP : G_FETCH;
                    tmr_nxt   = SDIV_M1;
                end
            end
            G_FETCH: begin
                state_nxt = G_SETUP;
                tmr_nxt   = SDIV_M1;
            end
            LATCH: begin
                if (tmr == '0) state_nxt = GAP;
                else           tmr_nxt = tmr - TW'(1);
            end
            GAP, GS_WAIT: decide = 1'b1;
            default: state_nxt = C_SETUP;
        endcase

        if (decide) begin
            if (do_ctrl) begin
                state_nxt = C_SETUP;
                idx_nxt   = LAST_IDX;
                tmr_nxt   = SDIV_M1;
                force_nxt = CTRL_FORCE;   // a request landing on the clear is kept
                ref_nxt   = '0;
                mode_nxt  = 1'b1;
            end else if (ENABLE && FRAME_VALID) begin
                state_nxt = G_FETCH;
                idx_nxt   = LAST_IDX;
                mode_nxt  = 1'b0;
            end else begin
                state_nxt = GS_WAIT;
            end
        end

        lat_rise = (state_nxt == LATCH) && (state != LATCH);
        if (lat_rise && !mode_ctrl && (ref_cnt != REF_MAX))
            ref_nxt = ref_cnt + RW'(1);

        sclk_nxt    = (state_nxt == C_HIGH) || (state_nxt == G_HIGH);
        lat_nxt     = (state_nxt == LATCH);
        rd_en_nxt   = (state_nxt == G_FETCH);
        rd_addr_nxt = (state_nxt == G_FETCH) ? idx_nxt[AW-1:0] : RD_ADDR;
        ack_nxt     = lat_rise && !mode_ctrl;
        busy_nxt    = (state_nxt != GS_WAIT);
        cph_nxt     = mode_nxt && ((state_nxt == C_SETUP) || (state_nxt == C_HIGH) ||
                                   (state_nxt == LATCH) || (state_nxt == GAP));

        // RD_DATA arrives during the first G_SETUP cycle; capture it there.
        if ((state_nxt == C_SETUP) || (state_nxt == C_HIGH))
            sdo_nxt = {NUM_CHAINS{CTRL_WORD[idx_nxt[AW-1:0]]}};
        else if ((state == G_SETUP) && (tmr == SDIV_M1))
            sdo_nxt = RD_DATA;
        else
            sdo_nxt = SDO;
    end

endmodule

// File: tb/tb_tlc_chain_shifter.sv
// tb_tlc_chain_shifter
// Directed bench for tlc_chain_shifter: LATCH_SIZE=8, NUM_CHAINS=4,
// CTRL_WORD=8'hA5, CTRL_REFRESH=2, plus a SCLK_DIV=3 instance for phase timing.
module tb_tlc_chain_shifter;

    localparam int          LS = 8;
    localparam int          NC = 4;
    localparam logic [7:0]  CW = 8'hA5;

    logic CLK_10M = 1'b0;
    always #50 CLK_10M = ~CLK_10M;

    logic          rst = 1'b1, en = 1'b0, fv = 1'b0, force_p = 1'b0;
    logic [NC-1:0] rd_data = '0;
    logic          frame_ack, rd_en, sclk, lat, busy, ctrl_phase;
    logic [2:0]    rd_addr;
    logic [NC-1:0] sdo;

    logic          rst3 = 1'b1, en3 = 1'b0, fv3 = 1'b0, force3 = 1'b0;
    logic [NC-1:0] rd_data3 = '0;
    logic          frame_ack3, rd_en3, sclk3, lat3, busy3, ctrl_phase3;
    logic [2:0]    rd_addr3;
    logic [NC-1:0] sdo3;

    tlc_chain_shifter #(
        .LATCH_SIZE(LS), .NUM_CHAINS(NC), .SCLK_DIV(1), .LAT_WIDTH(1),
        .CTRL_REFRESH(2), .CTRL_WORD(CW)
    ) dut (
        .CLK_10M(CLK_10M), .RESET(rst), .ENABLE(en), .FRAME_VALID(fv),
        .FRAME_ACK(frame_ack), .CTRL_FORCE(force_p), .RD_EN(rd_en),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data), .SCLK(sclk), .LAT(lat),
        .SDO(sdo), .BUSY(busy), .CTRL_PHASE(ctrl_phase)
    );

    tlc_chain_shifter #(
        .LATCH_SIZE(LS), .NUM_CHAINS(NC), .SCLK_DIV(3), .LAT_WIDTH(1),
        .CTRL_REFRESH(0), .CTRL_WORD(CW)
    ) dut3 (
        .CLK_10M(CLK_10M), .RESET(rst3), .ENABLE(en3), .FRAME_VALID(fv3),
        .FRAME_ACK(frame_ack3), .CTRL_FORCE(force3), .RD_EN(rd_en3),
        .RD_ADDR(rd_addr3), .RD_DATA(rd_data3), .SCLK(sclk3), .LAT(lat3),
        .SDO(sdo3), .BUSY(busy3), .CTRL_PHASE(ctrl_phase3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Upstream frame source: registered read, data = bit index on every lane.
    logic [2:0] rd_a;
    always @(negedge CLK_10M) begin
        if (rd_en) begin
            rd_a = rd_addr;
            @(posedge CLK_10M);
            #1 rd_data = {1'b0, rd_a};
        end
    end

    int            cyc;
    logic [NC-1:0] rise_sdo[$];
    int            lat_at[$];
    logic          lat_fl[$];
    int            ack_at[$];
    int            rda[$];
    int            lat_len;
    logic          p_sclk, p_lat;

    task automatic clr();
        cyc = 0;
        rise_sdo.delete(); lat_at.delete(); lat_fl.delete();
        ack_at.delete(); rda.delete();
        lat_len = 0;
        p_sclk = sclk;
        p_lat  = lat;
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            @(negedge CLK_10M);
            cyc++;
            if (sclk && !p_sclk) rise_sdo.push_back(sdo);
            if (lat && !p_lat) begin
                lat_at.push_back(cyc);
                lat_fl.push_back(ctrl_phase);
            end
            if (lat) lat_len++;
            if (frame_ack) ack_at.push_back(cyc);
            if (rd_en) rda.push_back(int'(rd_addr));
            p_sclk = sclk;
            p_lat  = lat;
        end
    endtask

    // GS, CTRL, GS, GS, CTRL starting from refresh count 1 (or right after a
    // forced rewrite that follows one GS latch).
    int   seq_lat[5] = '{25, 43, 69, 95, 113};
    logic seq_ctl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   seq_ack[3] = '{25, 69, 95};

    task automatic chk_seq(input string tag);
        chk({tag, "_nlat"}, lat_at.size(), 5);
        chk({tag, "_nack"}, ack_at.size(), 3);
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_lat_at"}, (i < lat_at.size()) ? lat_at[i] : -1, seq_lat[i]);
            chk({tag, "_lat_ctl"}, (i < lat_fl.size()) ? 32'(lat_fl[i]) : 32'hx, 32'(seq_ctl[i]));
        end
        for (int i = 0; i < 3; i++)
            chk({tag, "_ack_at"}, (i < ack_at.size()) ? ack_at[i] : -1, seq_ack[i]);
    endtask

    logic s3[0:63];
    logic l3[0:63];
    logic r3[0:63];
    int   idle_hits;

    initial begin
        // reset state
        repeat (3) @(negedge CLK_10M);
        chk("rst_sclk", sclk, 0);
        chk("rst_lat", lat, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_ack", frame_ack, 0);
        chk("rst_busy", busy, 1);
        chk("rst_cphase", ctrl_phase, 1);

        // control latch after reset release, ENABLE low
        clr();
        rst = 1'b0;
        watch(20);
        chk("t1_nrise", rise_sdo.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("t1_sdo", (i < rise_sdo.size()) ? 32'(rise_sdo[i]) : 32'hx,
                CW[7-i] ? 32'hF : 32'h0);
        chk("t1_nlat", lat_at.size(), 1);
        chk("t1_lat_at", (lat_at.size() > 0) ? lat_at[0] : -1, 16);
        chk("t1_lat_len", lat_len, 1);
        chk("t1_lat_ctl", (lat_fl.size() > 0) ? 32'(lat_fl[0]) : 32'hx, 1);
        chk("t1_nack", ack_at.size(), 0);
        chk("t1_busy", busy, 0);
        chk("t1_cphase", ctrl_phase, 0);

        // single grayscale frame
        en = 1'b1;
        fv = 1'b1;
        clr();
        watch(26);
        fv = 1'b0;
        watch(2);
        chk("t2_nrd", rda.size(), 8);
        chk("t2_nrise", rise_sdo.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_rd_addr", (i < rda.size()) ? rda[i] : -1, 7 - i);
            chk("t2_sdo", (i < rise_sdo.size()) ? 32'(rise_sdo[i]) : 32'hx, 32'(7 - i));
        end
        chk("t2_lat_at", (lat_at.size() > 0) ? lat_at[0] : -1, 25);
        chk("t2_lat_ctl", (lat_fl.size() > 0) ? 32'(lat_fl[0]) : 32'hx, 0);
        chk("t2_nack", ack_at.size(), 1);
        chk("t2_ack_at", (ack_at.size() > 0) ? ack_at[0] : -1, 25);
        chk("t2_busy", busy, 0);

        // FRAME_VALID held: automatic control refresh after 2 GS latches
        fv = 1'b1;
        clr();
        watch(114);
        fv = 1'b0;
        watch(2);
        chk_seq("t3");
        chk("t3_busy", busy, 0);

        // CTRL_FORCE during a GS frame with refresh count 0
        fv = 1'b1;
        clr();
        watch(13);
        force_p = 1'b1;
        watch(1);
        force_p = 1'b0;
        watch(100);
        fv = 1'b0;
        watch(2);
        chk_seq("t4");

        // reset during G_HIGH of bit 4
        fv = 1'b1;
        clr();
        watch(12);
        chk("t5_pre_sclk", sclk, 1);
        rst = 1'b1;
        watch(1);
        chk("t5_sclk", sclk, 0);
        chk("t5_lat", lat, 0);
        chk("t5_sdo", sdo, 0);
        chk("t5_rd_en", rd_en, 0);
        chk("t5_busy", busy, 1);
        chk("t5_cphase", ctrl_phase, 1);
        watch(1);
        chk("t5_abort_ack", ack_at.size(), 0);
        chk("t5_abort_lat", lat_at.size(), 0);
        clr();
        rst = 1'b0;
        watch(17);
        fv = 1'b0;
        watch(2);
        chk("t5_nlat", lat_at.size(), 1);
        chk("t5_lat_at", (lat_at.size() > 0) ? lat_at[0] : -1, 16);
        chk("t5_lat_ctl", (lat_fl.size() > 0) ? 32'(lat_fl[0]) : 32'hx, 1);
        chk("t5_nack", ack_at.size(), 0);
        chk("t5_sdo0", (rise_sdo.size() > 0) ? 32'(rise_sdo[0]) : 32'hx, 32'hF);

        // SCLK_DIV=3 instance: control bit timing, idle, grayscale bit timing
        rst3 = 1'b0;
        for (int i = 1; i <= 52; i++) begin
            @(negedge CLK_10M);
            s3[i] = sclk3;
            l3[i] = lat3;
        end
        chk("t6_c_lo2", s3[2], 0);
        chk("t6_c_hi3", s3[3], 1);
        chk("t6_c_hi5", s3[5], 1);
        chk("t6_c_lo6", s3[6], 0);
        chk("t6_c_lo8", s3[8], 0);
        chk("t6_c_hi9", s3[9], 1);
        chk("t6_lat47", l3[47], 0);
        chk("t6_lat48", l3[48], 1);
        chk("t6_lat49", l3[49], 0);
        idle_hits = 0;
        repeat (10) begin
            @(negedge CLK_10M);
            if (sclk3 || rd_en3 || lat3) idle_hits++;
        end
        chk("t6_idle_act", idle_hits, 0);
        chk("t6_idle_busy", busy3, 0);
        en3 = 1'b1;
        fv3 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK_10M);
            s3[i] = sclk3;
            r3[i] = rd_en3;
        end
        fv3 = 1'b0;
        chk("t6_g_rd1", r3[1], 1);
        chk("t6_g_rd2", r3[2], 0);
        chk("t6_g_lo4", s3[4], 0);
        chk("t6_g_hi5", s3[5], 1);
        chk("t6_g_hi7", s3[7], 1);
        chk("t6_g_lo8", s3[8], 0);
        chk("t6_g_rd8", r3[8], 1);
        chk("t6_g_hi12", s3[12], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
